muldiv_unit: RTL

//  Execute-stage consumer of the 5-bit alucontrol code; runs the multi-cycle ops

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for the execute stage.
// Holds the pipeline through stall_req and pulses done when HI/LO are updated.
module muldiv_unit #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [4:0]  alucontrol,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] OP_MULT  = 5'b01111;
  localparam logic [4:0] OP_MULTU = 5'b11111;
  localparam logic [4:0] OP_DIV   = 5'b01110;
  localparam logic [4:0] OP_DIVU  = 5'b11110;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic        signed_q, signed_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic               is_mul, is_div, accept, op_signed;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u, product;
  logic        [32:0] rem_sh;
  logic               ge;
  logic        [31:0] rem_new, quot_new;

  assign is_mul    = (alucontrol == OP_MULT) || (alucontrol == OP_MULTU);
  assign is_div    = (alucontrol == OP_DIV)  || (alucontrol == OP_DIVU);
  assign accept    = ((state_q == IDLE) || (state_q == DONE)) && start && !flush && (is_mul || is_div);
  assign op_signed = ~alucontrol[4];
  assign stall_req = (state_q == MUL) || (state_q == DIV) || accept;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  // a_q holds the dividend magnitude and shifts left into the quotient as bits are produced
  always_comb begin
    prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    product  = signed_q ? $unsigned(prod_s) : prod_u;
    rem_sh   = {rem_q, a_q[31]};
    ge       = rem_sh >= {1'b0, b_q};
    rem_new  = ge ? (rem_sh[31:0] - b_q) : rem_sh[31:0];
    quot_new = {a_q[30:0], ge};

    state_d    = state_q;
    count_d    = count_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    signed_d   = signed_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d    = is_mul ? MUL : DIV;
          count_d    = 6'd0;
          signed_d   = op_signed;
          rem_d      = 32'd0;
          neg_quot_d = is_div && op_signed && (a[31] ^ b[31]);
          neg_rem_d  = is_div && op_signed && a[31];
          a_d        = (is_div && op_signed && a[31]) ? (~a + 32'd1) : a;
          b_d        = (is_div && op_signed && b[31]) ? (~b + 32'd1) : b;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else if (count_q == 6'(MUL_CYCLES - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          hi_d    = product[63:32];
          lo_d    = product[31:0];
        end else begin
          count_d = count_q + 6'd1;
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else if (b_q == 32'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
          lo_d    = 32'hFFFF_FFFF;
          hi_d    = neg_rem_q ? (~a_q + 32'd1) : a_q;
        end else if (count_q == 6'd31) begin
          state_d = DONE;
          done_d  = 1'b1;
          lo_d    = neg_quot_q ? (~quot_new + 32'd1) : quot_new;
          hi_d    = neg_rem_q ? (~rem_new + 32'd1) : rem_new;
        end else begin
          a_d     = quot_new;
          rem_d   = rem_new;
          count_d = count_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= 6'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      rem_q      <= 32'd0;
      signed_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      signed_q   <= signed_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule
